rps_dut_core: RTL and testbench



---
 rtl/rps_dut_core.sv | 128 ++++++++++++
 tb/tb_rps_dut_core.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/rps_dut_core.sv
// Rock-paper-scissors referee: captures one move per player, judges the
// round, and keeps a wrapping win count per player.
module rps_dut_core #(
    parameter int unsigned SCORE_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               r1,
    input  logic               p1,
    input  logic               s1,
    input  logic               go1,
    input  logic               r2,
    input  logic               p2,
    input  logic               s2,
    input  logic               go2,
    output logic [SCORE_W-1:0] score1,
    output logic [SCORE_W-1:0] score2,
    output logic               dut_busy
);

    localparam int unsigned MOVE_W = 3;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EVAL = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Moves are held as {rock, paper, scissors}
    localparam logic [MOVE_W-1:0] MV_R = 3'b100;
    localparam logic [MOVE_W-1:0] MV_P = 3'b010;
    localparam logic [MOVE_W-1:0] MV_S = 3'b001;

    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic              have1;
    logic              have2;
    logic [MOVE_W-1:0] mv1;
    logic [MOVE_W-1:0] mv2;
    logic [MOVE_W-1:0] in1_c;
    logic [MOVE_W-1:0] in2_c;
    logic              valid1_c;
    logic              valid2_c;
    logic              cap1_c;
    logic              cap2_c;
    logic              p1_wins_c;
    logic              p2_wins_c;

    // Input decode, capture qualification and round judgement
    always_comb begin
        in1_c     = {r1, p1, s1};
        in2_c     = {r2, p2, s2};
        valid1_c  = (in1_c == MV_R) || (in1_c == MV_P) || (in1_c == MV_S);
        valid2_c  = (in2_c == MV_R) || (in2_c == MV_P) || (in2_c == MV_S);
        cap1_c    = (state == ST_IDLE) && go1 && valid1_c && !have1;
        cap2_c    = (state == ST_IDLE) && go2 && valid2_c && !have2;
        p1_wins_c = ((mv1 == MV_R) && (mv2 == MV_S)) ||
                    ((mv1 == MV_S) && (mv2 == MV_P)) ||
                    ((mv1 == MV_P) && (mv2 == MV_R));
        p2_wins_c = ((mv2 == MV_R) && (mv1 == MV_S)) ||
                    ((mv2 == MV_S) && (mv1 == MV_P)) ||
                    ((mv2 == MV_P) && (mv1 == MV_R));
    end

    // Next-state logic: start judging once both moves are held after capture
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if ((have1 || cap1_c) && (have2 || cap2_c)) begin
                    state_nxt = ST_EVAL;
                end
            end
            ST_EVAL: state_nxt = ST_DONE;
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // State register with registered busy flag
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            dut_busy <= 1'b0;
        end else begin
            state    <= state_nxt;
            dut_busy <= (state_nxt != ST_IDLE);
        end
    end

    // Held moves: first valid move per player wins, cleared when the round ends
    always_ff @(posedge clk) begin
        if (rst) begin
            have1 <= 1'b0;
            have2 <= 1'b0;
            mv1   <= '0;
            mv2   <= '0;
        end else if (state == ST_DONE) begin
            have1 <= 1'b0;
            have2 <= 1'b0;
            mv1   <= '0;
            mv2   <= '0;
        end else begin
            if (cap1_c) begin
                have1 <= 1'b1;
                mv1   <= in1_c;
            end
            if (cap2_c) begin
                have2 <= 1'b1;
                mv2   <= in2_c;
            end
        end
    end

    // Score counters, updated once per judged round and wrapping at full scale
    always_ff @(posedge clk) begin
        if (rst) begin
            score1 <= '0;
            score2 <= '0;
        end else if (state == ST_EVAL) begin
            if (p1_wins_c) begin
                score1 <= score1 + SCORE_W'(1);
            end
            if (p2_wins_c) begin
                score2 <= score2 + SCORE_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_rps_dut_core.sv
// Bench for rps_dut_core: cycle-level referee model feeding a scoreboard,
// with a monitor that checks each round when dut_busy falls.
module tb_rps_dut_core;

    localparam int unsigned SW  = 4;
    localparam int          MOD = 1 << SW;

    localparam bit [2:0] R = 3'b100;
    localparam bit [2:0] P = 3'b010;
    localparam bit [2:0] S = 3'b001;
    localparam bit [2:0] N = 3'b000;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          r1 = 1'b0, p1 = 1'b0, s1 = 1'b0, go1 = 1'b0;
    logic          r2 = 1'b0, p2 = 1'b0, s2 = 1'b0, go2 = 1'b0;
    logic [SW-1:0] score1;
    logic [SW-1:0] score2;
    logic          dut_busy;

    rps_dut_core #(.SCORE_W(SW)) dut (
        .clk      (clk),
        .rst      (rst),
        .r1       (r1),
        .p1       (p1),
        .s1       (s1),
        .go1      (go1),
        .r2       (r2),
        .p2       (p2),
        .s2       (s2),
        .go2      (go2),
        .score1   (score1),
        .score2   (score2),
        .dut_busy (dut_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int s1;
        int s2;
        int len;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   pushes = 0;
    int   pops   = 0;

    // Reference model: lock counts the judging/finishing cycles after a round starts
    int lock = 0;
    bit h1 = 0, h2 = 0;
    int a1 = 0, a2 = 0;
    int e1 = 0, e2 = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic bit mv_valid(input bit [2:0] m);
        return $countones(m) == 1;
    endfunction

    // rock=0, paper=1, scissors=2
    function automatic int mv_idx(input bit [2:0] m);
        return m[2] ? 0 : (m[1] ? 1 : 2);
    endfunction

    task automatic model_step(input bit rv, input bit [2:0] m1, input bit g1,
                              input bit [2:0] m2, input bit g2);
        int d;
        if (rv) begin
            if (lock > 0) begin
                q.push_back('{0, 0, 3 - lock});
                pushes++;
            end
            lock = 0; h1 = 0; h2 = 0; e1 = 0; e2 = 0;
        end else if (lock == 2) begin
            d = (a1 - a2 + 3) % 3;
            if (d == 1) e1 = (e1 + 1) % MOD;
            else if (d == 2) e2 = (e2 + 1) % MOD;
            lock = 1;
        end else if (lock == 1) begin
            q.push_back('{e1, e2, 2});
            pushes++;
            h1 = 0; h2 = 0; lock = 0;
        end else begin
            if (g1 && mv_valid(m1) && !h1) begin h1 = 1; a1 = mv_idx(m1); end
            if (g2 && mv_valid(m2) && !h2) begin h2 = 1; a2 = mv_idx(m2); end
            if (h1 && h2) lock = 2;
        end
    endtask

    task automatic tick(input bit rv, input bit [2:0] m1, input bit g1,
                        input bit [2:0] m2, input bit g2);
        rst = rv;
        {r1, p1, s1} = m1;
        go1 = g1;
        {r2, p2, s2} = m2;
        go2 = g2;
        model_step(rv, m1, g1, m2, g2);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(0, N, 0, N, 0);
    endtask

    task automatic round(input bit [2:0] m1, input bit [2:0] m2);
        tick(0, m1, 1, m2, 1);
        idle(2);
    endtask

    // Monitor: a falling dut_busy marks the end of a round; compare against the scoreboard
    initial begin : monitor
        int   blen;
        bit   pb;
        exp_t e;
        blen = 0;
        pb   = 0;
        forever begin
            @(negedge clk);
            if (dut_busy) begin
                blen++;
            end else if (pb) begin
                if (q.size() == 0) begin
                    check("unexpected_round", 1, 0);
                end else begin
                    e = q.pop_front();
                    pops++;
                    check("round_score1", int'(score1), e.s1);
                    check("round_score2", int'(score2), e.s2);
                    check("round_busy_len", blen, e.len);
                end
                blen = 0;
            end
            pb = dut_busy;
        end
    end

    initial begin : stim
        int base;
        bit [2:0] m1, m2;

        // Reset for three cycles
        tick(1, N, 0, N, 0);
        tick(1, N, 0, N, 0);
        tick(1, N, 0, N, 0);
        idle(2);
        check("reset_score1", int'(score1), 0);
        check("reset_score2", int'(score2), 0);
        check("reset_busy", int'(dut_busy), 0);

        // Basic wins for player 1
        tick(0, R, 1, S, 1);
        check("busy_after_capture", int'(dut_busy), 1);
        tick(0, N, 0, N, 0);
        check("busy_in_done", int'(dut_busy), 1);
        tick(0, N, 0, N, 0);
        check("busy_released", int'(dut_busy), 0);
        check("win1_score1", int'(score1), 1);
        check("win1_score2", int'(score2), 0);
        round(P, R);
        check("win2_score1", int'(score1), 2);

        // Player 2 win, then tie
        round(R, P);
        check("p2win_score2", int'(score2), 1);
        round(S, S);
        check("tie_score1", int'(score1), 2);
        check("tie_score2", int'(score2), 1);

        // Staggered capture: first move held, later go1 ignored
        tick(0, R, 1, N, 0);
        tick(0, N, 0, N, 0);
        tick(0, P, 1, N, 0);
        tick(0, N, 0, N, 0);
        tick(0, N, 0, S, 1);
        idle(2);
        check("stagger_score1", int'(score1), 3);

        // Non-one-hot move is not captured
        tick(0, 3'b110, 1, R, 1);
        idle(2);
        check("invalid_not_busy", int'(dut_busy), 0);
        tick(0, S, 1, N, 0);
        idle(2);
        check("invalid_score2", int'(score2), 2);

        // go pulses during EVAL/DONE produce no extra round
        tick(0, R, 1, S, 1);
        tick(0, P, 1, R, 1);
        tick(0, S, 1, P, 1);
        idle(3);
        check("lockout_score1", int'(score1), 4);
        check("lockout_busy", int'(dut_busy), 0);

        // Reset at edge k+1 aborts the round
        tick(1, N, 0, N, 0);
        tick(0, R, 1, S, 1);
        tick(1, N, 0, N, 0);
        idle(2);
        check("abort_score1", int'(score1), 0);
        check("abort_score2", int'(score2), 0);

        // Wrap: MOD straight player 1 wins return score1 to zero
        for (int i = 0; i < MOD; i++) round(S, P);
        check("wrap_score1", int'(score1), 0);

        // Held go inputs start back-to-back rounds
        base = int'(score2);
        for (int i = 0; i < 9; i++) tick(0, R, 1, P, 1);
        idle(3);
        check("held_go_score2", int'(score2), (base + 3) % MOD);

        // Randomized traffic with occasional invalid moves and resets
        for (int i = 0; i < 600; i++) begin
            m1 = ($urandom_range(0, 4) == 0) ? 3'($urandom) : (3'b100 >> $urandom_range(0, 2));
            m2 = ($urandom_range(0, 4) == 0) ? 3'($urandom) : (3'b100 >> $urandom_range(0, 2));
            tick($urandom_range(0, 79) == 0, m1, 1'($urandom), m2, 1'($urandom));
        end
        idle(5);

        check("queue_drained", q.size(), 0);
        check("pushes_popped", pops, pushes);
        check("final_score1", int'(score1), e1);
        check("final_score2", int'(score2), e2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
